// File: rtl/vram_writer_pkg.sv
// Screen geometry, fill/control codes and writer state encoding.
// Shared by the character writer and the VGA display reader.
package vram_writer_pkg;

    localparam int unsigned VW_COLS  = 40;
    localparam int unsigned VW_ROWS  = 24;
    localparam logic [5:0]  VW_BLANK = 6'h20;
    localparam logic [6:0]  VW_CR    = 7'h0D;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        SCROLL = 2'd2,
        CLEAR  = 2'd3
    } vw_state_e;

    typedef struct packed {
        logic       printable;
        logic       newline;
        logic [5:0] code;
    } vw_char_t;

    // Lower-case range folds onto upper case; control codes other than CR are dropped.
    function automatic vw_char_t decode_char(input logic [6:0] c);
        vw_char_t   d;
        logic [6:0] m;
        m           = (c >= 7'h60) ? (c - 7'h20) : c;
        d.printable = (c >= 7'h20);
        d.newline   = (c == VW_CR);
        d.code      = m[5:0];
        return d;
    endfunction

endpackage

// File: rtl/vram_writer.sv
// Character-to-VRAM writer: places printable characters at the cursor,
// handles CR/wrap newlines, hardware scroll via a row offset, and full clear.
module vram_writer
    import vram_writer_pkg::*;
#(
    parameter int unsigned COLS  = VW_COLS,
    parameter int unsigned ROWS  = VW_ROWS,
    parameter logic [5:0]  BLANK = VW_BLANK
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic        clr,
    output logic [10:0] w_addr,
    output logic        w_en,
    output logic [5:0]  w_data,
    output logic [4:0]  top_row,
    output logic [4:0]  cur_row,
    output logic [5:0]  cur_col,
    output logic        busy
);

    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    vw_state_e   state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic        w_en_q, w_en_d;
    logic [10:0] w_addr_q, w_addr_d;
    logic [5:0]  w_data_q, w_data_d;
    logic [4:0]  top_q, top_d;
    logic [4:0]  row_q, row_d;
    logic [5:0]  col_q, col_d;
    logic        busy_q, busy_d;

    vw_char_t    dc;
    logic        do_nl;
    logic [4:0]  wr_row;
    logic [4:0]  new_top;
    logic [4:0]  blank_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            w_en_q   <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= BLANK;
            top_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            w_en_q   <= w_en_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            top_q    <= top_d;
            row_q    <= row_d;
            col_q    <= col_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_en_d    = 1'b0;
        w_addr_d  = w_addr_q;
        w_data_d  = w_data_q;
        top_d     = top_q;
        row_d     = row_q;
        col_d     = col_q;
        do_nl     = 1'b0;
        dc        = decode_char(char_in);
        wr_row    = top_q + row_q;
        new_top   = top_q + 5'd1;
        blank_row = new_top + LAST_ROW;

        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (char_valid) begin
                    if (dc.printable) begin
                        state_d  = WRITE;
                        w_en_d   = 1'b1;
                        w_addr_d = {wr_row, col_q};
                        w_data_d = dc.code;
                    end else if (dc.newline) begin
                        do_nl = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (col_q < LAST_COL) begin
                    col_d   = col_q + 6'd1;
                    state_d = IDLE;
                end else begin
                    do_nl = 1'b1;
                end
            end
            SCROLL: begin
                if (cnt_q[5:0] == LAST_COL) begin
                    state_d = IDLE;
                end else begin
                    cnt_d    = cnt_q + 12'd1;
                    w_en_d   = 1'b1;
                    w_addr_d = {w_addr_q[10:6], cnt_q[5:0] + 6'd1};
                    w_data_d = BLANK;
                end
            end
            CLEAR: begin
                // Bit 11 of the counter marks that address 2047 has been issued.
                if (cnt_q[11]) begin
                    state_d = IDLE;
                    top_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    w_en_d   = 1'b1;
                    w_addr_d = cnt_q[10:0];
                    w_data_d = BLANK;
                    cnt_d    = cnt_q + 12'd1;
                end
            end
            default: state_d = CLEAR;
        endcase

        // Shared newline path for CR in IDLE and column wrap after WRITE.
        if (do_nl) begin
            col_d = '0;
            if (row_q < LAST_ROW) begin
                row_d   = row_q + 5'd1;
                state_d = IDLE;
            end else begin
                state_d  = SCROLL;
                top_d    = new_top;
                cnt_d    = '0;
                w_en_d   = 1'b1;
                w_addr_d = {blank_row, 6'd0};
                w_data_d = BLANK;
            end
        end

        busy_d = (state_d != IDLE);
    end

    assign char_ready = (state_q == IDLE) && !clr;
    assign w_en       = w_en_q;
    assign w_addr     = w_addr_q;
    assign w_data     = w_data_q;
    assign top_row    = top_q;
    assign cur_row    = row_q;
    assign cur_col    = col_q;
    assign busy       = busy_q;

endmodule

// File: doc/vram_writer.md
VRAM_WRITER -- requirements
Module: vram_writer

Interface
REQ-001 SHALL have parameters COLS (default 40, characters per visible row), ROWS (default 24, visible rows) and BLANK (default 6'h20, fill code).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port char_in, input, 7 bits: ASCII character from the CPU display port.
REQ-005 SHALL have port char_valid, input, 1 bit: char_in holds a character.
REQ-006 SHALL have port char_ready, output, 1 bit: writer accepts a character this cycle.
REQ-007 SHALL have port clr, input, 1 bit: request a full-screen clear.
REQ-008 SHALL have port w_addr, output, 11 bits: VRAM write address, {phys_row[4:0], col[5:0]}.
REQ-009 SHALL have port w_en, output, 1 bit: VRAM write strobe.
REQ-010 SHALL have port w_data, output, 6 bits: VRAM write data.
REQ-011 SHALL have port top_row, output, 5 bits: physical row shown as visible row 0, for the display reader.
REQ-012 SHALL have port cur_row (5 bits, logical row 0..ROWS-1) and port cur_col (6 bits, 0..COLS-1), outputs: cursor position.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 SHALL use a registered FSM with states IDLE, WRITE, SCROLL and CLEAR; all outputs except char_ready SHALL be registered.
REQ-015 SHALL drive char_ready = (state==IDLE) && !clr; a character SHALL be accepted only when char_valid && char_ready.
REQ-016 SHALL give clr priority over char_valid in the same IDLE cycle; clr outside IDLE SHALL be ignored, not latched.
REQ-017 SHALL map accepted 0x60-0x7F by subtracting 0x20; 0x20-0x5F SHALL be printable with code = char[5:0]; 0x0D (CR) SHALL be a newline; all other codes SHALL be consumed with no write and no cursor change.
REQ-018 For a printable character: IDLE->WRITE, and in the WRITE cycle w_en=1, w_addr={(top_row+cur_row) mod 32, cur_col}, w_data=code; latency from accept to w_en SHALL be exactly 1 cycle.
REQ-019 After WRITE: if cur_col<COLS-1, cur_col increments and the FSM returns to IDLE; otherwise a newline is performed.
REQ-020 A newline (CR or wrap) SHALL set cur_col=0; if cur_row<ROWS-1, cur_row increments and the FSM goes to IDLE, else the FSM goes to SCROLL with cur_row unchanged.
REQ-021 On SCROLL entry top_row SHALL increment mod 32; SCROLL SHALL then write BLANK to columns 0..COLS-1 of physical row (new top_row+ROWS-1) mod 32, one per cycle (COLS cycles), then return to IDLE.
REQ-022 CLEAR SHALL write BLANK to all 2048 addresses, 0..2047 ascending, one per cycle, then set cur_row=cur_col=0, top_row=0 and go to IDLE.
REQ-023 w_en SHALL be 0 in IDLE, and w_en/w_addr/w_data SHALL change only on clk edges.
REQ-024 Row arithmetic SHALL be 5-bit and wrap naturally; column addresses COLS..63 SHALL never be written except by CLEAR.

Reset
REQ-025 While rst_n=0: state=CLEAR, clear address=0, w_en=0, w_addr=0, w_data=BLANK, top_row=0, cur_row=0, cur_col=0, busy=1, char_ready=0.
REQ-026 After release, the full CLEAR (2048 cycles) SHALL run before the first character is accepted.
REQ-027 Reset asserted mid-SCROLL or mid-WRITE SHALL abandon the operation with no further write and restart per REQ-025.

Structure
REQ-028 Screen geometry (COLS, ROWS), BLANK, the CR code and the state encoding SHALL live in a shared package/include also used by the VGA display reader.
REQ-029 SHALL be a single module with no sub-modules; the cursor/row-offset arithmetic stays inline.

Verification
REQ-030 Reset release -> 2048 consecutive w_en pulses at addresses 0..2047 with data 6'h20, then char_ready=1, cursor (0,0), top_row=0.
REQ-031 char 0x41 accepted at (0,0) -> next cycle w_en=1, w_addr=11'h000, w_data=6'h01; then cur_col=1.
REQ-032 41 printable chars from (0,0) -> 41st written at w_addr=11'h040 (row 1, col 0); cur_col=1; 0x61 writes 6'h01.
REQ-033 CR at (23,5), top_row=0 -> top_row=1, 40 writes of 6'h20 at addresses 11'h600..11'h627, cur_row=23, cur_col=0, char_ready low for 40 cycles.
REQ-034 33 scrolls from reset -> top_row wraps 31->0->1, blanked row address wraps; clr and char_valid together in IDLE -> char not accepted, CLEAR runs.
REQ-035 Char 0x07 accepted -> no w_en, cursor unchanged; rst_n pulsed low mid-SCROLL -> w_en drops immediately, CLEAR restarts at address 0.
